// File: rtl/seed_one_round_core_pkg.sv
// rtl/seed_one_round_core_pkg.sv - SEED constants, S-boxes and key-schedule helpers
package seed_one_round_core_pkg;

  localparam int          ROUNDS = 16;
  localparam logic [31:0] KC1    = 32'h9E3779B9;
  localparam logic [7:0]  M0     = 8'hFC;
  localparam logic [7:0]  M1     = 8'hF3;
  localparam logic [7:0]  M2     = 8'hCF;
  localparam logic [7:0]  M3     = 8'h3F;

  typedef enum logic [1:0] {ST_IDLE, ST_KSETUP, ST_RUN, ST_DONE} state_e;

  localparam logic [7:0] S1 [0:255] = '{
    8'hA9, 8'h85, 8'hD6, 8'hD3, 8'h54, 8'h1D, 8'hAC, 8'h25, 8'h5D, 8'h43, 8'h18, 8'h1E, 8'h51, 8'hFC, 8'hCA, 8'h63,
    8'h28, 8'h44, 8'h20, 8'h9D, 8'hE0, 8'hE2, 8'hC8, 8'h17, 8'hA5, 8'h8F, 8'h03, 8'h7B, 8'hBB, 8'h13, 8'hD2, 8'hEE,
    8'h70, 8'h8C, 8'h3F, 8'hA8, 8'h32, 8'hDD, 8'hF6, 8'h74, 8'hEC, 8'h95, 8'h0B, 8'h57, 8'h5C, 8'h5B, 8'hBD, 8'h01,
    8'h24, 8'h1C, 8'h73, 8'h98, 8'h10, 8'hCC, 8'hF2, 8'hD9, 8'h2C, 8'hE7, 8'h72, 8'h83, 8'h9B, 8'hD1, 8'h86, 8'hC9,
    8'h60, 8'h50, 8'hA3, 8'hEB, 8'h0D, 8'hB6, 8'h9E, 8'h4F, 8'hB7, 8'h5A, 8'hC6, 8'h78, 8'hA6, 8'h12, 8'hAF, 8'hD5,
    8'h61, 8'hC3, 8'hB4, 8'h41, 8'h52, 8'h7D, 8'h8D, 8'h08, 8'h1F, 8'h99, 8'h00, 8'h19, 8'h04, 8'h53, 8'hF7, 8'hE1,
    8'hFD, 8'h76, 8'h2F, 8'h27, 8'hB0, 8'h8B, 8'h0E, 8'hAB, 8'hA2, 8'h6E, 8'h93, 8'h4D, 8'h69, 8'h7C, 8'h09, 8'h0A,
    8'hBF, 8'hEF, 8'hF3, 8'hC5, 8'h87, 8'h14, 8'hFE, 8'h64, 8'hDE, 8'h2E, 8'h4B, 8'h1A, 8'h06, 8'h21, 8'h6B, 8'h66,
    8'h02, 8'hF5, 8'h92, 8'h8A, 8'h0C, 8'hB3, 8'h7E, 8'hD0, 8'h7A, 8'h47, 8'h96, 8'hE5, 8'h26, 8'h80, 8'hAD, 8'hDF,
    8'hA1, 8'h30, 8'h37, 8'hAE, 8'h36, 8'h15, 8'h22, 8'h38, 8'hF4, 8'hA7, 8'h45, 8'h4C, 8'h81, 8'hE9, 8'h84, 8'h97,
    8'h35, 8'hCB, 8'hCE, 8'h3C, 8'h71, 8'h11, 8'hC7, 8'h89, 8'h75, 8'hFB, 8'hDA, 8'hF8, 8'h94, 8'h59, 8'h82, 8'hC4,
    8'hFF, 8'h49, 8'h39, 8'h67, 8'hC0, 8'hCF, 8'hD7, 8'hB8, 8'h0F, 8'h8E, 8'h42, 8'h23, 8'h91, 8'h6C, 8'hDB, 8'hA4,
    8'h34, 8'hF1, 8'h48, 8'hC2, 8'h6F, 8'h3D, 8'h2D, 8'h40, 8'hBE, 8'h3E, 8'hBC, 8'hC1, 8'hAA, 8'hBA, 8'h4E, 8'h55,
    8'h3B, 8'hDC, 8'h68, 8'h7F, 8'h9C, 8'hD8, 8'h4A, 8'h56, 8'h77, 8'hA0, 8'hED, 8'h46, 8'hB5, 8'h2B, 8'h65, 8'hFA,
    8'hE3, 8'hB9, 8'hB1, 8'h9F, 8'h5E, 8'hF9, 8'hE6, 8'hB2, 8'h31, 8'hEA, 8'h6D, 8'h5F, 8'hE4, 8'hF0, 8'hCD, 8'h88,
    8'h16, 8'h3A, 8'h58, 8'hD4, 8'h62, 8'h29, 8'h07, 8'h33, 8'hE8, 8'h1B, 8'h05, 8'h79, 8'h90, 8'h6A, 8'h2A, 8'h9A
  };

  localparam logic [7:0] S2 [0:255] = '{
    8'h38, 8'hE8, 8'h2D, 8'hA6, 8'hCF, 8'hDE, 8'hB3, 8'hB8, 8'hAF, 8'h60, 8'h55, 8'hC7, 8'h44, 8'h6F, 8'h6B, 8'h5B,
    8'hC3, 8'h62, 8'h33, 8'hB5, 8'h29, 8'hA0, 8'hE2, 8'hA7, 8'hD3, 8'h91, 8'h11, 8'h06, 8'h1C, 8'hBC, 8'h36, 8'h4B,
    8'hEF, 8'h88, 8'h6C, 8'hA8, 8'h17, 8'hC4, 8'h16, 8'hF4, 8'hC2, 8'h45, 8'hE1, 8'hD6, 8'h3F, 8'h3D, 8'h8E, 8'h98,
    8'h28, 8'h4E, 8'hF6, 8'h3E, 8'hA5, 8'hF9, 8'h0D, 8'hDF, 8'hD8, 8'h2B, 8'h66, 8'h7A, 8'h27, 8'h2F, 8'hF1, 8'h72,
    8'h42, 8'hD4, 8'h41, 8'hC0, 8'h73, 8'h67, 8'hAC, 8'h8B, 8'hF7, 8'hAD, 8'h80, 8'h1F, 8'hCA, 8'h2C, 8'hAA, 8'h34,
    8'hD2, 8'h0B, 8'hEE, 8'hE9, 8'h5D, 8'h94, 8'h18, 8'hF8, 8'h57, 8'hAE, 8'h08, 8'hC5, 8'h13, 8'hCD, 8'h86, 8'hB9,
    8'hFF, 8'h7D, 8'hC1, 8'h31, 8'hF5, 8'h8A, 8'h6A, 8'hB1, 8'hD1, 8'h20, 8'hD7, 8'h02, 8'h22, 8'h04, 8'h68, 8'h71,
    8'h07, 8'hDB, 8'h9D, 8'h99, 8'h61, 8'hBE, 8'hE6, 8'h59, 8'hDD, 8'h51, 8'h90, 8'hDC, 8'h9A, 8'hA3, 8'hAB, 8'hD0,
    8'h81, 8'h0F, 8'h47, 8'h1A, 8'hE3, 8'hEC, 8'h8D, 8'hBF, 8'h96, 8'h7B, 8'h5C, 8'hA2, 8'hA1, 8'h63, 8'h23, 8'h4D,
    8'hC8, 8'h9E, 8'h9C, 8'h3A, 8'h0C, 8'h2E, 8'hBA, 8'h6E, 8'h9F, 8'h5A, 8'hF2, 8'h92, 8'hF3, 8'h49, 8'h78, 8'hCC,
    8'h15, 8'hFB, 8'h70, 8'h75, 8'h7F, 8'h35, 8'h10, 8'h03, 8'h64, 8'h6D, 8'hC6, 8'h74, 8'hD5, 8'hB4, 8'hEA, 8'h09,
    8'h76, 8'h19, 8'hFE, 8'h40, 8'h12, 8'hE0, 8'hBD, 8'h05, 8'hFA, 8'h01, 8'hF0, 8'h2A, 8'h5E, 8'hA9, 8'h56, 8'h43,
    8'h85, 8'h14, 8'h89, 8'h9B, 8'hB0, 8'hE5, 8'h48, 8'h79, 8'h97, 8'hFC, 8'h1E, 8'h82, 8'h21, 8'h8C, 8'h1B, 8'h5F,
    8'h77, 8'h54, 8'hB2, 8'h1D, 8'h25, 8'h4F, 8'h00, 8'h46, 8'hED, 8'h58, 8'h52, 8'hEB, 8'h7E, 8'hDA, 8'hC9, 8'hFD,
    8'h30, 8'h95, 8'h65, 8'h3C, 8'hB6, 8'hE4, 8'hBB, 8'h7C, 8'h0E, 8'h50, 8'h39, 8'h26, 8'h32, 8'h84, 8'h69, 8'h93,
    8'h37, 8'hE7, 8'h24, 8'hA4, 8'hCB, 8'h53, 8'h0A, 8'h87, 8'hD9, 8'h4C, 8'h83, 8'h8F, 8'hCE, 8'h3B, 8'h4A, 8'hB7
  };

  // KC for round idx (1..16) is KC1 rotated left by idx-1
  function automatic logic [31:0] kc_of(input logic [4:0] idx);
    logic [4:0] n;
    n = idx - 5'd1;
    return (KC1 << n) | (KC1 >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [127:0] ks_fwd(input logic [127:0] ks, input logic [4:0] idx);
    logic [63:0] a;
    logic [63:0] b;
    a = ks[127:64];
    b = ks[63:0];
    if (idx[0]) a = {a[7:0], a[63:8]};
    else        b = {b[55:0], b[63:56]};
    return {a, b};
  endfunction

  function automatic logic [127:0] ks_inv(input logic [127:0] ks, input logic [4:0] idx);
    logic [63:0] a;
    logic [63:0] b;
    a = ks[127:64];
    b = ks[63:0];
    if (idx[0]) a = {a[55:0], a[63:56]};
    else        b = {b[7:0], b[63:8]};
    return {a, b};
  endfunction

endpackage

// File: rtl/seed_g.sv
// rtl/seed_g.sv - combinational SEED G function (S-box layer plus masked byte mix)
module seed_g
  import seed_one_round_core_pkg::*;
(
  input  logic [31:0] x_i,
  output logic [31:0] z_o
);

  logic [7:0] y0, y1, y2, y3;

  assign y0 = S1[x_i[7:0]];
  assign y1 = S2[x_i[15:8]];
  assign y2 = S1[x_i[23:16]];
  assign y3 = S2[x_i[31:24]];

  assign z_o[7:0]   = (y0 & M0) ^ (y1 & M1) ^ (y2 & M2) ^ (y3 & M3);
  assign z_o[15:8]  = (y0 & M1) ^ (y1 & M2) ^ (y2 & M3) ^ (y3 & M0);
  assign z_o[23:16] = (y0 & M2) ^ (y1 & M3) ^ (y2 & M0) ^ (y3 & M1);
  assign z_o[31:24] = (y0 & M3) ^ (y1 & M0) ^ (y2 & M1) ^ (y3 & M2);

endmodule

// File: rtl/seed_one_round_core.sv
// rtl/seed_one_round_core.sv - SEED block cipher, one Feistel round per clock, on-the-fly key schedule
module seed_one_round_core
  import seed_one_round_core_pkg::*;
(
  input  logic         clk,
  input  logic         nreset,
  input  logic         data_rdy,
  input  logic         key_rdy,
  input  logic         EncDec,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         data_valid,
  output logic         key_valid,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         mode_q, mode_d;
  logic         kv_q, kv_d;
  logic         dv_q, dv_d;
  logic [127:0] key_q, key_d;
  logic [127:0] base_q, base_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] dout_q, dout_d;

  logic [4:0]   idx;
  logic [127:0] ks_next_fwd, ks_prev, ks_use, blk_in, round_out;
  logic [31:0]  kc, rk0, rk1, gk0_in, gk1_in;
  logic [31:0]  t0, t1, ga, gb, gc;
  logic [63:0]  l_in, r_in, f_out;

  // Decrypt rounds walk the key index down; key setup always walks it up
  assign idx = (mode_q && state_q != ST_KSETUP) ? (5'(ROUNDS) - {1'b0, rnd_q})
                                                : ({1'b0, rnd_q} + 5'd1);

  assign ks_next_fwd = ks_fwd(key_q, idx);
  assign ks_prev     = ks_inv(key_q, idx);
  assign ks_use      = mode_q ? ks_prev : key_q;
  assign kc          = kc_of(idx);
  assign gk0_in      = ks_use[127:96] + ks_use[63:32] - kc;
  assign gk1_in      = ks_use[95:64] - ks_use[31:0] + kc;

  seed_g u_gk0 (.x_i(gk0_in), .z_o(rk0));
  seed_g u_gk1 (.x_i(gk1_in), .z_o(rk1));

  // Round 1 is applied straight from data_in on the accepting edge
  assign blk_in = (state_q == ST_RUN) ? blk_q : data_in;
  assign l_in   = blk_in[127:64];
  assign r_in   = blk_in[63:0];
  assign t0     = r_in[63:32] ^ rk0;
  assign t1     = r_in[31:0] ^ rk1;

  seed_g u_ga (.x_i(t0 ^ t1), .z_o(ga));
  seed_g u_gb (.x_i(t0 + ga), .z_o(gb));
  seed_g u_gc (.x_i(gb + ga), .z_o(gc));

  assign f_out     = {gb + gc, gc};
  assign round_out = {r_in, l_in ^ f_out};

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    mode_d  = mode_q;
    kv_d    = kv_q;
    dv_d    = 1'b0;
    key_d   = key_q;
    base_d  = base_q;
    blk_d   = blk_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (key_rdy) begin
          key_d  = data_in;
          mode_d = EncDec;
          rnd_d  = 4'd0;
          if (EncDec) begin
            kv_d    = 1'b0;
            state_d = ST_KSETUP;
          end else begin
            kv_d   = 1'b1;
            base_d = data_in;
          end
        end else if (data_rdy && kv_q) begin
          blk_d   = round_out;
          key_d   = mode_q ? ks_prev : ks_next_fwd;
          rnd_d   = 4'd1;
          state_d = ST_RUN;
        end
      end
      ST_KSETUP: begin
        key_d = ks_next_fwd;
        if (rnd_q == 4'(ROUNDS - 1)) begin
          rnd_d   = 4'd0;
          base_d  = ks_next_fwd;
          kv_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_RUN: begin
        blk_d = round_out;
        if (rnd_q == 4'(ROUNDS - 1)) begin
          dout_d  = {round_out[63:0], round_out[127:64]};
          dv_d    = 1'b1;
          key_d   = base_q;
          rnd_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          key_d = mode_q ? ks_prev : ks_next_fwd;
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
      kv_q    <= 1'b0;
      dv_q    <= 1'b0;
      key_q   <= '0;
      base_q  <= '0;
      blk_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
      kv_q    <= kv_d;
      dv_q    <= dv_d;
      key_q   <= key_d;
      base_q  <= base_d;
      blk_q   <= blk_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign key_valid  = kv_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seed_one_round_core.sv
// tb/tb_seed_one_round_core.sv - directed known-answer and control-protocol bench
module tb_seed_one_round_core;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT0  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] CT0  = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
  localparam logic [127:0] CT1  = 128'hC11F22F20140505084483597E4370F43;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         data_rdy = 1'b0;
  logic         key_rdy = 1'b0;
  logic         EncDec = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] data_out;
  logic         data_valid;
  logic         key_valid;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seed_one_round_core dut (
    .clk        (clk),
    .nreset     (nreset),
    .data_rdy   (data_rdy),
    .key_rdy    (key_rdy),
    .EncDec     (EncDec),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .key_valid  (key_valid),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k, input logic mode);
    data_in = k;
    EncDec  = mode;
    key_rdy = 1'b1;
    tick;
    key_rdy = 1'b0;
    EncDec  = 1'b0;
    data_in = '0;
  endtask

  // Pulse data_rdy, watch cycles 1..19; optionally fire a data_rdy while busy
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp,
                           input bit inject, input string tag);
    int lat;
    int nval;
    logic [127:0] got;
    lat  = -1;
    nval = 0;
    got  = '0;
    data_in  = pt;
    data_rdy = 1'b1;
    tick;
    data_rdy = 1'b0;
    data_in  = '0;
    check({tag, " busy_c1"}, 128'(busy), 128'(1'b1));
    for (int c = 1; c < 20; c++) begin
      if (data_valid) begin
        nval++;
        if (lat < 0) begin
          lat = c;
          got = data_out;
          check({tag, " busy_c16"}, 128'(busy), 128'(1'b1));
        end
      end
      if (inject && c == 5) begin
        data_in  = ~pt;
        data_rdy = 1'b1;
      end
      tick;
      data_rdy = 1'b0;
      data_in  = '0;
    end
    check({tag, " latency"}, 128'(lat), 128'(16));
    check({tag, " result"}, got, exp);
    check({tag, " valid_pulses"}, 128'(nval), 128'(1));
    check({tag, " hold"}, data_out, exp);
    check({tag, " idle_after"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    int cnt;

    repeat (3) tick;
    check("rst data_out", data_out, 128'h0);
    check("rst data_valid", 128'(data_valid), 128'(1'b0));
    check("rst key_valid", 128'(key_valid), 128'(1'b0));
    check("rst busy", 128'(busy), 128'(1'b0));
    nreset = 1'b1;
    tick;

    data_in  = PT0;
    data_rdy = 1'b1;
    tick;
    data_rdy = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (data_valid || busy) cnt++;
      tick;
    end
    check("nokey no_activity", 128'(cnt), 128'(0));

    load_key(128'h0, 1'b0);
    check("enc0 key_valid", 128'(key_valid), 128'(1'b1));
    check("enc0 busy", 128'(busy), 128'(1'b0));
    run_block(PT0, CT0, 1'b0, "kat0");

    load_key(KEY1, 1'b0);
    check("enc1 key_valid", 128'(key_valid), 128'(1'b1));
    run_block(128'h0, CT1, 1'b1, "kat1a");
    run_block(128'h0, CT1, 1'b0, "kat1b");

    load_key(KEY1, 1'b1);
    check("dec key_valid_c1", 128'(key_valid), 128'(1'b0));
    check("dec busy_c1", 128'(busy), 128'(1'b1));
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick;
    end
    check("dec setup_cycles", 128'(cnt), 128'(16));
    check("dec key_valid", 128'(key_valid), 128'(1'b1));
    run_block(CT1, 128'h0, 1'b0, "dec_a");
    run_block(CT1, 128'h0, 1'b1, "dec_b");

    data_in  = KEY1;
    EncDec   = 1'b0;
    key_rdy  = 1'b1;
    data_rdy = 1'b1;
    tick;
    key_rdy  = 1'b0;
    data_rdy = 1'b0;
    data_in  = '0;
    check("both busy", 128'(busy), 128'(1'b0));
    check("both key_valid", 128'(key_valid), 128'(1'b1));
    run_block(128'h0, CT1, 1'b0, "rekey");

    data_in  = PT0;
    data_rdy = 1'b1;
    tick;
    data_rdy = 1'b0;
    repeat (5) tick;
    nreset = 1'b0;
    tick;
    check("midrst data_out", data_out, 128'h0);
    check("midrst data_valid", 128'(data_valid), 128'(1'b0));
    check("midrst key_valid", 128'(key_valid), 128'(1'b0));
    check("midrst busy", 128'(busy), 128'(1'b0));
    nreset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 3) begin
        data_in  = PT0;
        data_rdy = 1'b1;
      end
      if (data_valid) cnt++;
      tick;
      data_rdy = 1'b0;
    end
    check("midrst no_valid", 128'(cnt), 128'(0));
    check("midrst out_zero", data_out, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
